// File: rtl/mux2_tdm_capture.sv
// mux2_tdm_capture: two-channel round-robin deserializer that steers a
// 2:1 transmission-gate mux, shifts in DATA_W samples of its output and
// offers the word on a valid/ready port.
// Optional feature macro: MUX2_SETTLE_EN (one dead cycle after select).
// Ports:
//   clk, rst_n       clock, async active-low reset
//   req[1:0]         per-channel request
//   grant[1:0]       one-hot, channel currently captured
//   sel              mux select (0 -> I[0], 1 -> I[1])
//   mux_y            mux output, sampled on rising clk
//   out_data         captured word, MSB first sampled
//   out_ch           source channel of out_data
//   out_valid        word available
//   out_ready        consumer accept
//   busy             sequencer not idle
module mux2_tdm_capture #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req,
   output logic [1:0]        grant,
   output logic              sel,
   input  logic              mux_y,
   output logic [DATA_W-1:0] out_data,
   output logic              out_ch,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   localparam int CW = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SHIFT  = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t          state;
   logic [CW-1:0]   count;
   logic            last;
   logic            pick;

   // On a tie the channel not served last time wins.
   always_comb begin
      pick = 1'b0;
      if (req == 2'b11)
         pick = ~last;
      else
         pick = req[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sel       <= 1'b0;
         grant     <= 2'b00;
         out_data  <= '0;
         out_ch    <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         count     <= '0;
         last      <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  sel   <= pick;
                  grant <= {pick, ~pick};
                  last  <= pick;
                  count <= '0;
                  busy  <= 1'b1;
`ifdef MUX2_SETTLE_EN
                  state <= SETTLE;
`else
                  state <= SHIFT;
`endif
               end
            end
            SETTLE: begin
               state <= SHIFT;
            end
            SHIFT: begin
               out_data <= {out_data[DATA_W-2:0], mux_y};
               count    <= count + CW'(1);
               if (count == CW'(DATA_W - 1)) begin
                  grant     <= 2'b00;
                  out_ch    <= sel;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
